axi_lite_sram: RTL and testbench
================================

AXI_LITE_SRAM -- requirements
Module: axi_lite_sram

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 supported.
REQ-003 SHALL have parameter DEPTH, default 1024, number of 32-bit words.
REQ-004 SHALL have parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-005 SHALL have parameter LATENCY, default 1, wait cycles from request capture to response (0..15).
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have ports araddr in 32, arvalid in 1, arready out 1: read address channel.
REQ-009 SHALL have ports rdata out 32, rresp out 2, rvalid out 1, rready in 1: read data channel.
REQ-010 SHALL have ports awaddr in 32, awvalid in 1, awready out 1: write address channel.
REQ-011 SHALL have ports wdata in 32, wstrb in 4, wvalid in 1, wready out 1: write data channel.
REQ-012 SHALL have ports bresp out 2, bvalid out 1, bready in 1: write response channel.

Function
REQ-013 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP; arready=1 only in R_IDLE.
REQ-014 R_IDLE: arvalid&&arready SHALL capture araddr and go to R_WAIT (LATENCY>0) or R_RESP (LATENCY=0) next cycle.
REQ-015 R_WAIT SHALL count LATENCY cycles, then enter R_RESP; rdata/rresp sampled on that transition.
REQ-016 R_RESP: rvalid=1, rdata/rresp stable until rvalid&&rready; then R_IDLE next cycle.
REQ-017 Write FSM SHALL have states W_IDLE, W_WAIT, W_RESP; awready=1 in W_IDLE until AW captured; wready=1 in W_IDLE until W captured.
REQ-018 AW and W SHALL be accepted in either order or same cycle; leave W_IDLE only when both captured.
REQ-019 W_WAIT SHALL count LATENCY cycles; memory write with byte strobes committed on transition into W_RESP.
REQ-020 W_RESP: bvalid=1, bresp stable until bvalid&&bready; then W_IDLE next cycle.
REQ-021 Word index SHALL be (addr-BASE)>>2; addr[1:0] ignored.
REQ-022 addr outside [BASE, BASE+4*DEPTH) SHALL give resp 2'b11 (DECERR), rdata=0, write dropped; otherwise 2'b00 (OKAY).
REQ-023 Read and write channels SHALL run independently and concurrently.
REQ-024 Read sample and write commit to the same word in the same cycle SHALL return pre-write data.
REQ-025 Back-to-back: rready held high SHALL allow one read per LATENCY+2 cycles; no combinational valid->ready paths.

Reset
REQ-026 rst SHALL force both FSMs to IDLE; rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, counters=0.
REQ-027 arready, awready, wready SHALL be 0 while rst=1 and 1 the first cycle after.
REQ-028 Reset mid-transaction SHALL abandon it with no response; an uncommitted write SHALL not modify memory.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-030 Package axi_lite_pkg SHALL hold RESP_OKAY, RESP_SLVERR, RESP_DECERR and the rd_state_t/wr_state_t enums.
REQ-031 Storage SHALL be sub-module sram_core: one synchronous write port with 4-bit byte enable, one asynchronous read port.

Verification
REQ-032 Reset, then write 0x80000010 data 0xDEADBEEF strb 4'hF; read 0x80000010 -> rdata 0xDEADBEEF, rresp 0, rvalid exactly LATENCY+1 cycles after AR handshake.
REQ-033 Write 0x80000010 data 0x11223344 strb 4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-034 W sent 3 cycles before AW -> wready drops after W handshake, bvalid once after AW; bresp 0.
REQ-035 Read 0x7FFFFFFC and write 0x80001000 (DEPTH=1024) -> rresp 2'b11 rdata 0, bresp 2'b11, memory unchanged.
REQ-036 rready held low 5 cycles in R_RESP -> rvalid/rdata stable; arready=0 throughout; rst mid-R_WAIT -> rvalid never asserts, arready=1 next cycle after reset.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared response codes and FSM state types for the AXI-Lite SRAM slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

endpackage

// File: rtl/sram_core.sv
// Word-addressed storage: synchronous byte-enabled write, asynchronous read.
module sram_core #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_sram.sv
// AXI-Lite slave in front of a single-word-wide SRAM with programmable response latency.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready.
module axi_lite_sram
  import axi_lite_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output rd_state_t           rd_state_dbg,
  output wr_state_t           wr_state_dbg
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(4 * DEPTH);
  localparam logic [3:0]        LAT_LAST = 4'(LATENCY - 1);
  localparam bit                ZERO_LAT = (LATENCY == 0);

  function automatic logic hit(input logic [ADDR_W-1:0] a);
    return (a >= BASE_A) && ((a - BASE_A) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_A) >> 2);
  endfunction

  rd_state_t         rd_state;
  logic [3:0]        rd_cnt;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] rd_addr_eff;
  logic [DATA_W-1:0] mem_rdata;

  wr_state_t           wr_state;
  logic [3:0]          wr_cnt;
  logic                aw_done, w_done, aw_hs, w_hs, wr_both, wr_commit, mem_we;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_eff;
  logic [DATA_W-1:0]   wr_data_q, wr_data_eff;
  logic [DATA_W/8-1:0] wr_strb_q, wr_strb_eff;

  // Readies are gated by rst so they read 0 during reset and 1 the first cycle after.
  assign arready = (rd_state == R_IDLE) && !rst;
  assign awready = (wr_state == W_IDLE) && !aw_done && !rst;
  assign wready  = (wr_state == W_IDLE) && !w_done && !rst;

  assign rd_state_dbg = rd_state;
  assign wr_state_dbg = wr_state;

  // With zero latency the sample/commit happens on the capture edge, so use the live bus.
  assign rd_addr_eff = (rd_state == R_IDLE) ? araddr : rd_addr_q;
  assign wr_addr_eff = aw_done ? wr_addr_q : awaddr;
  assign wr_data_eff = w_done ? wr_data_q : wdata;
  assign wr_strb_eff = w_done ? wr_strb_q : wstrb;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign wr_both   = (wr_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
  assign wr_commit = ZERO_LAT ? wr_both : ((wr_state == W_WAIT) && (wr_cnt == LAT_LAST));
  assign mem_we    = wr_commit && hit(wr_addr_eff) && !rst;

  sram_core #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_core (
    .clk   (clk),
    .we    (mem_we),
    .be    (wr_strb_eff),
    .waddr (word_idx(wr_addr_eff)),
    .wdata (wr_data_eff),
    .raddr (word_idx(rd_addr_eff)),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      rd_cnt    <= '0;
      rd_addr_q <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: if (arvalid) begin
          rd_addr_q <= araddr;
          rd_cnt    <= '0;
          if (ZERO_LAT) begin
            rd_state <= R_RESP;
            rvalid   <= 1'b1;
            rdata    <= hit(rd_addr_eff) ? mem_rdata : '0;
            rresp    <= hit(rd_addr_eff) ? RESP_OKAY : RESP_DECERR;
          end else begin
            rd_state <= R_WAIT;
          end
        end
        R_WAIT: if (rd_cnt == LAT_LAST) begin
          rd_state <= R_RESP;
          rvalid   <= 1'b1;
          rdata    <= hit(rd_addr_eff) ? mem_rdata : '0;
          rresp    <= hit(rd_addr_eff) ? RESP_OKAY : RESP_DECERR;
        end else begin
          rd_cnt <= rd_cnt + 4'd1;
        end
        R_RESP: if (rready) begin
          rvalid   <= 1'b0;
          rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      wr_cnt    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            wr_addr_q <= awaddr;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wr_data_q <= wdata;
            wr_strb_q <= wstrb;
            w_done    <= 1'b1;
          end
          if (wr_both) begin
            wr_cnt <= '0;
            if (ZERO_LAT) begin
              wr_state <= W_RESP;
              bvalid   <= 1'b1;
              bresp    <= hit(wr_addr_eff) ? RESP_OKAY : RESP_DECERR;
            end else begin
              wr_state <= W_WAIT;
            end
          end
        end
        W_WAIT: if (wr_cnt == LAT_LAST) begin
          wr_state <= W_RESP;
          bvalid   <= 1'b1;
          bresp    <= hit(wr_addr_eff) ? RESP_OKAY : RESP_DECERR;
        end else begin
          wr_cnt <= wr_cnt + 4'd1;
        end
        W_RESP: if (bready) begin
          bvalid   <= 1'b0;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Randomized bench for axi_lite_sram: directed corner cases plus a random mix against a word-array model.
module tb_axi_lite_sram;
  import axi_lite_pkg::*;

  localparam int          LAT   = 1;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  rd_state_t   rd_state_dbg;
  wr_state_t   wr_state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] ref_mem [int];
  logic [33:0] exp_q [$];

  always #5 clk = ~clk;

  axi_lite_sram #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: flat word array, byte-merge on strobe, range rule on byte address.
  function automatic bit ref_hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!ref_hit(a)) return;
    w = ref_mem.exists(ref_idx(a)) ? ref_mem[ref_idx(a)] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[ref_idx(a)] = w;
  endfunction

  function automatic logic [33:0] ref_read(input logic [31:0] a);
    if (!ref_hit(a)) return {RESP_DECERR, 32'h0};
    return {RESP_OKAY, ref_mem[ref_idx(a)]};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0: a = BASE - 32'($urandom_range(1, 64));
      1: a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
      default: ;
    endcase
    return a;
  endfunction

  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int t;
    araddr = addr;
    arvalid = 1'b1;
    t = 0;
    while (arready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) check("ar_timeout", 0, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    araddr = $urandom;
    lat = 1;
    while (rvalid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    data = rdata;
    resp = rresp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("r_stable", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, resp, data});
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("r_drop", rvalid, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int hold, output logic [1:0] resp);
    int cyc, t;
    bit aw_ok, w_ok, aw_now, w_now;
    cyc = 0; aw_ok = 0; w_ok = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_ok && w_ok) && cyc < 50) begin
      awvalid = !aw_ok && (cyc >= aw_dly);
      wvalid  = !w_ok && (cyc >= w_dly);
      aw_now  = awvalid && awready;
      w_now   = wvalid && wready;
      @(posedge clk); #1;
      aw_ok |= aw_now;
      w_ok  |= w_now;
      if (aw_ok ^ w_ok) check("half_ready", {awready, wready, bvalid}, {!aw_ok, !w_ok, 1'b0});
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_ok && w_ok)) check("w_timeout", 0, 1);
    t = 1;
    while (bvalid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    check("wr_lat", t, LAT + 1);
    resp = bresp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("b_stable", {bvalid, awready, wready, bresp}, {1'b1, 1'b0, 1'b0, resp});
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("b_drop", bvalid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, a, n;
    logic [1:0]  r;
    logic [33:0] exp_r, r_obs;
    logic [1:0]  b_obs;
    int          lat, t;
    bit          seen, got_r, got_b;

    araddr = '0; arvalid = 0; rready = 0; awaddr = '0; awvalid = 0;
    wdata = '0; wstrb = '0; wvalid = 0; bready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {arready, awready, wready}, 3'b000);
    check("rst_valid", {rvalid, bvalid}, 2'b00);
    check("rst_regs", {rdata, rresp, bresp}, 36'h0);
    check("rst_state", {rd_state_dbg, wr_state_dbg}, {R_IDLE, W_IDLE});
    rst = 1'b0;
    #1;
    check("ready_after_rst", {arready, awready, wready}, 3'b111);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      do_write(BASE + 32'(i * 4), d, 4'hF, 0, 0, 0, r);
      ref_write(BASE + 32'(i * 4), d, 4'hF);
    end

    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r);
    ref_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    check("full_bresp", r, RESP_OKAY);
    do_read(32'h8000_0010, 0, d, r, lat);
    check("full_read", {r, d}, {RESP_OKAY, 32'hDEAD_BEEF});
    check("rd_lat", lat, LAT + 1);

    do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 0, 1, r);
    ref_write(32'h8000_0010, 32'h1122_3344, 4'b0101);
    do_read(32'h8000_0010, 0, d, r, lat);
    check("strb_read", {r, d}, {RESP_OKAY, 32'hDE22_BE44});

    do_write(32'h8000_0020, 32'h0BAD_CAFE, 4'hF, 3, 0, 0, r);
    ref_write(32'h8000_0020, 32'h0BAD_CAFE, 4'hF);
    check("w_first_bresp", r, RESP_OKAY);
    do_read(32'h8000_0020, 5, d, r, lat);
    check("hold_read", {r, d}, ref_read(32'h8000_0020));

    do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 0, r);
    ref_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF);
    do_read(32'h7FFF_FFFC, 0, d, r, lat);
    check("oor_read", {r, d}, {RESP_DECERR, 32'h0});
    do_write(32'h8000_1000, 32'h5555_AAAA, 4'hF, 0, 0, 0, r);
    check("oor_bresp", r, RESP_DECERR);
    do_read(32'h8000_0000, 0, d, r, lat);
    check("oor_unchanged", {r, d}, {RESP_OKAY, 32'hCAFE_F00D});

    // Reset during the read wait state.
    araddr = BASE + 32'd4;
    arvalid = 1'b1;
    check("ar_idle", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_ar", arready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ar_after_rst", arready, 1);
    seen = 0;
    repeat (6) begin if (rvalid === 1'b1) seen = 1; @(posedge clk); #1; end
    check("no_rvalid", seen, 0);

    // Reset during the write wait state: the write must not land.
    awaddr = BASE + 32'hC; wdata = ~ref_mem[3]; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin if (bvalid === 1'b1) seen = 1; @(posedge clk); #1; end
    check("no_bvalid", seen, 0);
    do_read(BASE + 32'hC, 0, d, r, lat);
    check("rst_write_dropped", {r, d}, ref_read(BASE + 32'hC));

    // Same-cycle read and write of one word: the read sees the old value.
    a = BASE + 32'h14;
    n = $urandom;
    exp_r = ref_read(a);
    araddr = a; awaddr = a; wdata = n; wstrb = 4'hF;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    got_r = 0; got_b = 0; t = 0; r_obs = '1; b_obs = '1;
    while (!(got_r && got_b) && t < 30) begin
      if (rvalid === 1'b1 && !got_r) begin got_r = 1; r_obs = {rresp, rdata}; end
      if (bvalid === 1'b1 && !got_b) begin got_b = 1; b_obs = bresp; end
      @(posedge clk); #1;
      t++;
    end
    rready = 1'b0; bready = 1'b0;
    check("conc_read_old", r_obs, exp_r);
    check("conc_bresp", {got_b, b_obs}, {1'b1, RESP_OKAY});
    ref_write(a, n, 4'hF);
    do_read(a, 0, d, r, lat);
    check("conc_read_new", {r, d}, ref_read(a));

    for (int k = 0; k < 60; k++) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        wstrb = 4'($urandom_range(0, 15));
        do_write(a, d, wstrb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r);
        check("rnd_bresp", r, ref_hit(a) ? RESP_OKAY : RESP_DECERR);
        ref_write(a, d, wstrb);
      end else begin
        exp_q.push_back(ref_read(a));
        do_read(a, $urandom_range(0, 2), d, r, lat);
        check("rnd_read", {r, d}, exp_q.pop_front());
        check("rnd_lat", lat, LAT + 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
